// File: rtl/interval_timer_ctrl.sv
// Interval timer: counts 0..period_reg, pulses tick on each terminal count,
// supports periodic and one-shot modes with pause/resume/abort.
module interval_timer_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_load,
  input  logic [WIDTH-1:0] cfg_period,
  input  logic             cfg_mode,
  input  logic             start,
  input  logic             stop,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             tick,
  output logic             done
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_HOLD, S_DONE} state_e;

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] period_q, period_d;
  logic             mode_q, mode_d;
  logic             tick_q, tick_d;

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    period_d = period_q;
    mode_d   = mode_q;
    tick_d   = 1'b0;

    // Config is only accepted while the counter is not in flight.
    if (cfg_load && (state_q == S_IDLE || state_q == S_DONE)) begin
      period_d = cfg_period;
      mode_d   = cfg_mode;
    end

    case (state_q)
      S_IDLE: begin
        count_d = '0;
        if (start && !stop) state_d = S_RUN;
      end
      S_RUN: begin
        // A stop on the terminal cycle defers the tick until after resume.
        if (stop) begin
          state_d = S_HOLD;
        end else if (count_q == period_q) begin
          tick_d = 1'b1;
          if (mode_q) count_d = '0;
          else        state_d = S_DONE;
        end else begin
          count_d = count_q + ONE;
        end
      end
      S_HOLD: begin
        if (stop) begin
          state_d = S_IDLE;
          count_d = '0;
        end else if (start) begin
          state_d = S_RUN;
        end
      end
      S_DONE: begin
        if (stop) begin
          state_d = S_IDLE;
          count_d = '0;
        end else if (start) begin
          state_d = S_RUN;
          count_d = '0;
        end
      end
      default: begin
        state_d = S_IDLE;
        count_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      count_q  <= '0;
      tick_q   <= 1'b0;
      period_q <= '1;
      mode_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      tick_q   <= tick_d;
      period_q <= period_d;
      mode_q   <= mode_d;
    end
  end

  assign count = count_q;
  assign tick  = tick_q;
  assign busy  = (state_q == S_RUN);
  assign done  = (state_q == S_DONE);

endmodule

// File: doc/interval_timer_ctrl.md
INTERVAL_TIMER_CTRL -- requirements
Module: interval_timer_ctrl

Interface
REQ-001 Parameter: WIDTH, default 8, counter and period width in bits.
REQ-002 clk  input  1  rising-edge clock; all state changes on this edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 cfg_load  input  1  capture cfg_period and cfg_mode; honoured only in IDLE or DONE.
REQ-005 cfg_period  input  WIDTH  terminal count value; counter runs 0..cfg_period inclusive.
REQ-006 cfg_mode  input  1  0 = one-shot, 1 = periodic.
REQ-007 start  input  1  begin, resume or restart counting.
REQ-008 stop  input  1  pause in RUN, abort to IDLE from HOLD or DONE.
REQ-009 count  output  WIDTH  registered current count value.
REQ-010 busy  output  1  high while state is RUN.
REQ-011 tick  output  1  registered one-cycle pulse on each terminal count.
REQ-012 done  output  1  high while state is DONE (one-shot completed).

Function
REQ-013 States: IDLE, RUN, HOLD, DONE. Encoding is implementer's choice. busy and done decode from registered state.
REQ-014 Internal registers period_reg (WIDTH) and mode_reg (1) are loaded by cfg_load in IDLE or DONE, one edge after assertion. cfg_load in RUN or HOLD is ignored.
REQ-015 IDLE transitions:
- start=1 -> RUN, count<=0.
- Otherwise remain in IDLE, count holds 0.
REQ-016 RUN, per edge, with stop=0:
- count!=period_reg: count<=count+1, tick<=0.
- count==period_reg: tick<=1.
- Periodic: count<=0, remain in RUN.
- One-shot: count holds, state<=DONE.
REQ-017 tick therefore pulses in the cycle after count equals period_reg. Period P gives a tick interval of P+1 cycles in periodic mode.
REQ-018 Boundary, period_reg==0: periodic gives count fixed at 0 and tick high every cycle from the 2nd RUN cycle. One-shot gives DONE after 1 RUN cycle.
REQ-019 Boundary, period_reg==2^WIDTH-1: count reaches all-ones and never overflows. The wrap to 0 happens only through REQ-016.
REQ-020 RUN with stop=1 -> HOLD; count holds; tick<=0. This applies even if count==period_reg on that edge: the terminal event is deferred, not lost.
REQ-021 HOLD transitions:
- start=1 and stop=0 -> RUN, resume from held count.
- stop=1 -> IDLE, count<=0.
- Neither -> hold.
REQ-022 DONE transitions:
- start=1 and stop=0 -> RUN, count<=0.
- stop=1 -> IDLE, count<=0.
- Otherwise hold, with count==period_reg.
REQ-023 Simultaneous start and stop in any state: stop has priority. In IDLE, both asserted -> remain IDLE.
REQ-024 start while already in RUN is ignored; no restart occurs.
REQ-025 tick is low in every cycle not following a terminal count in RUN.
REQ-026 cfg_load and start on the same edge in IDLE: the new period and mode are captured and RUN is entered, and the first RUN cycle uses the new period_reg.
REQ-027 All arithmetic is unsigned WIDTH-bit. There are no combinational paths from inputs to outputs.

Reset
REQ-028 rst=1 on an edge forces, in any state including mid-RUN:
- state=IDLE, count=0, tick=0.
- period_reg = all-ones, mode_reg = 0.
REQ-029 rst has priority over every other input on the same edge. Outputs reflect reset values in the cycle after that edge.
REQ-030 busy=0 and done=0 while in reset.

Verification
REQ-031 Periodic: cfg_load with period=3, mode=1, then start -> count sequence 0,1,2,3,0,1,... and tick high 1 cycle after each count=3, every 4 cycles; busy=1 throughout.
REQ-032 One-shot: period=5, mode=0, start -> count 0..5, then tick pulses once, done=1, count holds 5, busy=0. A later start restarts count from 0.
REQ-033 Pause: periodic period=10; stop at count=4 -> HOLD, count stays 4 for 3 cycles; start -> resumes at 5. Stop asserted at count=10 defers the tick until after resume.
REQ-034 Edges: period=0 periodic gives tick every cycle from 2nd RUN cycle with count=0. Period=255 counts to 255, ticks, wraps to 0 with no overflow glitch.
REQ-035 Priority and reset: start+stop together in IDLE -> stays IDLE. cfg_load during RUN leaves the period unchanged. rst at count=7 in RUN -> next cycle count=0, IDLE, tick=0, done=0, busy=0.
